// File: rtl/cdc_req_tx.sv
// cdc_req_tx -- transmitting end of a 4-phase req/ack handshake.
//
// Moves a DATA_WIDTH word out of the clk domain. req_out and data_out come
// straight from flops. The returning ack_async is only ever observed through
// a SYNC_DEPTH-stage synchronizer chain.
//
// Optional feature macro: CDC_TX_TIMEOUT_EN
//   Defined   : REQ/REL waits are bounded by TIMEOUT_CYCLES. An expired wait
//               aborts to IDLE and sets the sticky timeout_err output.
//   Undefined : no counter and no timeout_err port; waits are unbounded.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   send_valid  in   producer offers send_data
//   send_data   in   word to transfer
//   send_ready  out  block can accept a word this cycle
//   send_done   out  one-cycle pulse on handshake completion
//   req_out     out  registered request to the far domain
//   data_out    out  registered word, stable while req_out/ack is high
//   ack_async   in   acknowledge from the far domain (asynchronous)
//   timeout_err out  sticky abort flag (CDC_TX_TIMEOUT_EN only)
module cdc_req_tx #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned SYNC_DEPTH     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  send_valid,
  input  logic [DATA_WIDTH-1:0] send_data,
  output logic                  send_ready,
  output logic                  send_done,
  output logic                  req_out,
  output logic [DATA_WIDTH-1:0] data_out,
  input  logic                  ack_async
`ifdef CDC_TX_TIMEOUT_EN
  ,
  output logic                  timeout_err
`endif
);

  if (SYNC_DEPTH < 2) begin : g_bad_sync_depth
    $error("cdc_req_tx: SYNC_DEPTH must be 2 or greater");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("cdc_req_tx: TIMEOUT_CYCLES must be 1 or greater");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    REL  = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    req_q, req_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic                    done_q, done_d;
  logic [SYNC_DEPTH-1:0]   sync_q;
  logic                    ack_sync;
  logic                    ack_next;

  assign ack_sync = sync_q[SYNC_DEPTH-1];
  // Value ack_sync takes after the coming edge. REL completes on the edge
  // where ack_sync falls, so send_done and send_ready appear together with
  // the low ack_sync rather than one cycle later.
  assign ack_next = sync_q[SYNC_DEPTH-2];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], ack_async};
    end
  end

`ifdef CDC_TX_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeout_err = err_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    done_d  = 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    case (state_q)
      IDLE: begin
        if (send_valid && send_ready) begin
          state_d = REQ;
          req_d   = 1'b1;
          data_d  = send_data;
`ifdef CDC_TX_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      REQ: begin
        if (ack_sync) begin
          state_d = REL;
          req_d   = 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          req_d   = 1'b0;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
`endif
        end
      end
      REL: begin
        if (!ack_next) begin
          state_d = IDLE;
          done_d  = 1'b1;
`ifdef CDC_TX_TIMEOUT_EN
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
`endif
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  assign send_ready = (state_q == IDLE) && !ack_sync;
  assign send_done  = done_q;
  assign req_out    = req_q;
  assign data_out   = data_q;

endmodule

// File: tb/tb_cdc_req_tx.sv
module tb_cdc_req_tx;
  localparam int unsigned DW  = 8;
  localparam int unsigned SD  = 2;
  localparam int unsigned TMO = 16;
`ifdef CDC_TX_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          send_valid;
  logic [DW-1:0] send_data;
  logic          send_ready;
  logic          send_done;
  logic          req_out;
  logic [DW-1:0] data_out;
  logic          ack_async;
`ifdef CDC_TX_TIMEOUT_EN
  logic          timeout_err;
`endif

  always #5 clk = ~clk;

  cdc_req_tx #(
    .DATA_WIDTH    (DW),
    .SYNC_DEPTH    (SD),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .send_valid (send_valid),
    .send_data  (send_data),
    .send_ready (send_ready),
    .send_done  (send_done),
    .req_out    (req_out),
    .data_out   (data_out),
    .ack_async  (ack_async)
`ifdef CDC_TX_TIMEOUT_EN
    ,
    .timeout_err(timeout_err)
`endif
  );

  int passed = 0;
  int total  = 0;

  // Reference model: A[n] is ack_async as seen at the n-th edge since reset.
  // The synchronized ack after edge m is simply A[m-SD+1].
  logic          A [0:4095];
  int            n;
  int            m_phase;   // 0 idle, 1 waiting for ack, 2 waiting for release
  logic          m_req;
  logic [DW-1:0] m_data;
  logic          m_done;
  logic          m_err;
  int            m_entry;
  logic          far_ack;
  int            far_wait;

  function automatic logic sync_after(int m);
    int idx = m - int'(SD) + 1;
    if (idx < 1 || idx > 4095) return 1'b0;
    return A[idx];
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s at edge %0d: got %0h expected %0h", nm, n, act, exp);
  endtask

  task automatic model_edge(input logic sv, input logic [DW-1:0] sd);
    m_done = 1'b0;
    case (m_phase)
      0: if (sv && !sync_after(n - 1)) begin
           m_phase = 1; m_req = 1'b1; m_data = sd; m_entry = n;
         end
      1: if (sync_after(n - 1)) begin
           m_phase = 2; m_req = 1'b0; m_entry = n;
         end else if (TMO_EN && (n - m_entry) >= int'(TMO)) begin
           m_phase = 0; m_req = 1'b0; m_err = 1'b1;
         end
      2: if (!sync_after(n)) begin
           m_phase = 0; m_done = 1'b1;
         end else if (TMO_EN && (n - m_entry) >= int'(TMO)) begin
           m_phase = 0; m_err = 1'b1;
         end
      default: m_phase = 0;
    endcase
  endtask

  task automatic check_model();
    chk("req_out", 32'(req_out), 32'(m_req));
    chk("data_out", 32'(data_out), 32'(m_data));
    chk("send_done", 32'(send_done), 32'(m_done));
    chk("send_ready", 32'(send_ready), 32'((m_phase == 0) && !sync_after(n)));
`ifdef CDC_TX_TIMEOUT_EN
    chk("timeout_err", 32'(timeout_err), 32'(m_err));
`endif
  endtask

  // One clock: inputs are applied 1 time unit after the previous edge,
  // outputs are compared 1 time unit after this edge.
  task automatic step(input logic sv, input logic [DW-1:0] sd, input logic ack);
    send_valid = sv;
    send_data  = sd;
    ack_async  = ack;
    @(posedge clk);
    n++;
    if (n < 4096) A[n] = ack;
    model_edge(sv, sd);
    #1;
    check_model();
  endtask

  task automatic far_next();
    if (far_wait > 0) far_wait--;
    else if (far_ack != m_req) begin
      far_ack  = m_req;
      far_wait = $urandom_range(0, 3);
    end
  endtask

  task automatic do_reset(input logic ack);
    rst_n = 1'b0; send_valid = 1'b0; send_data = '0; ack_async = ack;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 4096; i++) A[i] = 1'b0;
    m_phase = 0; m_req = 1'b0; m_data = '0; m_done = 1'b0; m_err = 1'b0; m_entry = 0;
    far_ack = 1'b0; far_wait = 0;
    chk("rst_req", 32'(req_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    chk("rst_done", 32'(send_done), 32'd0);
    chk("rst_ready", 32'(send_ready), 32'd1);
  endtask

  typedef struct {
    logic          sv;
    logic [DW-1:0] sd;
    logic          ack;
    logic          req;
    logic [DW-1:0] data;
    logic          ready;
    logic          done;
  } vec_t;

  vec_t tbl [9];

  initial begin
    int obs, mdone, cnt, rel_edge;

    // Single transfer of 8'hA5: far side acks one cycle after req rises and
    // releases one cycle after req falls.
    tbl[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[3] = '{1'b0, 8'h00, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0};
    tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
    tbl[5] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'hA5, 1'b0, 1'b0};
    tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b1};
    tbl[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'hA5, 1'b1, 1'b0};

    rst_n = 1'b0; send_valid = 1'b0; send_data = '0; ack_async = 1'b0;
    do_reset(1'b0);

    for (int i = 0; i < 9; i++) begin
      step(tbl[i].sv, tbl[i].sd, tbl[i].ack);
      chk($sformatf("tbl%0d_req", i), 32'(req_out), 32'(tbl[i].req));
      chk($sformatf("tbl%0d_data", i), 32'(data_out), 32'(tbl[i].data));
      chk($sformatf("tbl%0d_ready", i), 32'(send_ready), 32'(tbl[i].ready));
      chk($sformatf("tbl%0d_done", i), 32'(send_done), 32'(tbl[i].done));
    end

    // Back-pressure: 8'h3C held valid during an 8'h11 transfer.
    far_ack = 1'b0; far_wait = 0;
    step(1'b1, 8'h11, 1'b0);
    obs = -1; mdone = -1;
    for (int i = 0; i < 40; i++) begin
      far_next();
      step(1'b1, 8'h3C, far_ack);
      if (mdone < 0 && m_done) mdone = n;
      if (obs < 0 && data_out == 8'h3C) obs = n;
    end
    chk("bp_accept_edge", 32'(obs), 32'(mdone + 1));

    // Stuck ack from reset, then released.
    do_reset(1'b1);
    cnt = 0;
    for (int i = 0; i < 2; i++) step(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 8'hE7, 1'b1);
      if (req_out) cnt++;
    end
    chk("stuck_req_rises", 32'(cnt), 32'd0);
    rel_edge = n + 1;
    obs = -1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (obs < 0 && send_ready) obs = n;
    end
    chk("stuck_release_edge", 32'(obs), 32'(rel_edge + int'(SD) - 1));

    // Reset asserted while waiting for ack.
    do_reset(1'b0);
    step(1'b1, 8'h77, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("pre_reset_req", 32'(req_out), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_req", 32'(req_out), 32'd0);
    chk("async_reset_data", 32'(data_out), 32'd0);
    do_reset(1'b0);
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (send_done) cnt++;
    end
    chk("mid_reset_no_done", 32'(cnt), 32'd0);

`ifdef CDC_TX_TIMEOUT_EN
    // Abort with ack never arriving, then a good transfer keeps the flag.
    do_reset(1'b0);
    step(1'b1, 8'h5A, 1'b0);
    obs = -1;
    for (int i = 0; i < 24; i++) begin
      step(1'b0, 8'h00, 1'b0);
      if (obs < 0 && !req_out) obs = n;
    end
    chk("tmo_req_fall_edge", 32'(obs), 32'(1 + int'(TMO)));
    chk("tmo_err_set", 32'(timeout_err), 32'd1);
    far_ack = 1'b0; far_wait = 0;
    step(1'b1, 8'hC3, 1'b0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      far_next();
      step(1'b0, 8'h00, far_ack);
      if (send_done) cnt++;
    end
    chk("tmo_followup_done", 32'(cnt), 32'd1);
    chk("tmo_err_sticky", 32'(timeout_err), 32'd1);
`endif

    // Randomized traffic with a randomly slow far side and occasional glitches.
    do_reset(1'b0);
    for (int i = 0; i < 400; i++) begin
      logic a;
      far_next();
      a = far_ack;
      if ($urandom_range(0, 19) == 0) a = ~a;
      step(1'($urandom_range(0, 1)), DW'($urandom), a);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cdc_req_tx.md
Name: cdc_req_tx

Overview:
- Transmitting end of a 4-phase req/ack handshake that carries a data word from the clk domain to a consumer in another clock domain.
- Complements the input synchronizer chain. This block drives req_out and data_out as stable, glitch-free registers, and brings the returning ack_async back through an internal SYNC_DEPTH-stage flop chain.
- Used for game-state and score words leaving the main clock domain.

Parameters:
- DATA_WIDTH, 8, width of the transferred word.
- SYNC_DEPTH, 2, flop stages on ack_async; must be 2 or greater.
- TIMEOUT_CYCLES, 1024, abort limit; used only when CDC_TX_TIMEOUT_EN is defined; must be 1 or greater.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- send_valid  input  1  producer offers send_data this cycle.
- send_data  input  DATA_WIDTH  word to transfer.
- send_ready  output  1  block can accept a word this cycle.
- send_done  output  1  one-cycle pulse when a handshake fully completes.
- req_out  output  1  request to far domain; registered.
- data_out  output  DATA_WIDTH  transferred word; registered, stable while req_out or ack is high.
- ack_async  input  1  acknowledge from far domain; asynchronous to clk.
- timeout_err  output  1  sticky abort flag; present only with CDC_TX_TIMEOUT_EN.

Behaviour:
- Reset (rst_n low, takes effect immediately, no clock needed):
  - state = IDLE; req_out = 0, data_out = 0, send_done = 0.
  - All sync stages = 0, timeout counter = 0, timeout_err = 0.
- ack_sync is the output of stage SYNC_DEPTH of a shift chain clocked by clk, with stage 1 fed from ack_async. ack_async is never used directly by any logic.
- send_ready = (state == IDLE) && !ack_sync. It is combinational from registered state only; no input-to-output path.
- Accept: send_valid && send_ready on edge N:
  - data_out <= send_data and req_out <= 1, both visible after edge N; state -> REQ.
  - send_valid while send_ready is 0 is ignored; the producer must hold it. Nothing is queued.
- State REQ (req_out = 1):
  - Waits for ack_sync = 1. With ack_async high before edge k, ack_sync is high after edge k+SYNC_DEPTH-1.
  - At edge k+SYNC_DEPTH: req_out <= 0, state -> REL.
- State REL (req_out = 0, data_out held):
  - Waits for ack_sync = 0. On that edge, state -> IDLE and send_done = 1 for exactly one cycle.
  - send_ready rises in the same cycle as send_done.
- data_out changes only on an accept. It holds its value in IDLE after completion.
- ack_sync high while in IDLE (far side stuck or a late ack):
  - send_ready stays 0 and no request is issued until ack_sync falls.
- ack_async glitch shorter than one clk period in REQ: if it reaches ack_sync, it is treated as a valid ack. Protocol correctness is the far side's responsibility.
- Minimum transfer period for SYNC_DEPTH = 2, with the far side acking instantly, is 2*SYNC_DEPTH+1 = 5 cycles from accept to send_done.
- Reset mid-transfer: req_out drops asynchronously and the transfer is lost. No send_done is issued.

Optional Feature:
- Macro: CDC_TX_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and to REL, and increments every cycle in those states.
  - When it reaches TIMEOUT_CYCLES without the awaited ack_sync level, the block goes to IDLE, req_out <= 0 and timeout_err <= 1.
  - timeout_err is sticky; only rst_n clears it. No send_done is issued for an aborted transfer.
  - The send_ready ack_sync gating still applies after an abort.
- Not defined: no counter and no timeout_err port; REQ and REL wait indefinitely.

Test Plan:
- Reset/idle: rst_n=0 then 1, ack_async=0 -> req_out=0, data_out=0, send_ready=1, send_done=0.
- Single transfer, SYNC_DEPTH=2:
  - Stimulus: send 8'hA5 at edge 0; model acks 1 cycle after req rises and drops ack 1 cycle after req falls.
  - Required: req_out high edges 1..4, data_out=8'hA5 throughout, send_done at exactly one cycle, send_ready=0 until send_done.
- Back-pressure: hold send_valid with 8'h3C during a transfer of 8'h11 -> 8'h3C accepted only in the send_done cycle; data_out never changes while req_out or ack_sync is 1.
- Stuck ack: force ack_async=1 from reset -> send_ready=0 and req_out never rises; release ack -> send_ready=1 after SYNC_DEPTH edges.
- Mid-transfer reset: assert rst_n=0 asynchronously in REQ -> req_out=0 with no clock edge; no send_done after release.
- Timeout (macro defined, TIMEOUT_CYCLES=16): send with ack held 0 -> req_out falls and timeout_err=1 after 16 cycles in REQ; timeout_err stays 1 across a following successful transfer.
